// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : forwarding-select encodings, tracker state type, width helpers
// Rev 1.0
// ============================================================================
package hazard_pkg;

    // Decode-stage comparator muxes
    localparam logic [1:0] FWD_D_RF = 2'b00;
    localparam logic [1:0] FWD_D_M  = 2'b01;
    localparam logic [1:0] FWD_D_W  = 2'b10;

    // Execute-stage ALU operand muxes (note the swapped M/W encoding)
    localparam logic [1:0] FWD_E_RF = 2'b00;
    localparam logic [1:0] FWD_E_W  = 2'b01;
    localparam logic [1:0] FWD_E_M  = 2'b10;

    typedef enum logic [0:0] {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Counter needs at least one bit even when no multi-cycle stall exists.
    function automatic int mc_cnt_width(input int lat);
        return (clog2(lat) < 1) ? 1 : clog2(lat);
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/multicycle_tracker.sv
`default_nettype none
// ============================================================================
// multicycle_tracker : IDLE/BUSY FSM and down-counter for mul/div occupancy of E
// Rev 1.0
// ============================================================================
module multicycle_tracker
    import hazard_pkg::*;
#(
    parameter int MULTI_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic multistall_o,
    output logic busy_o
);

    localparam int CNT_W = mc_cnt_width(MULTI_LAT);

    generate
        if (MULTI_LAT > 1) begin : g_multi
            localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 2);
            localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

            mc_state_e        state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             stall;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= MC_IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // The op stalls on its first cycle in E, then MULTI_LAT-2 more;
            // the cnt==0 cycle in BUSY is the release cycle.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                stall   = 1'b0;
                case (state_q)
                    MC_IDLE: begin
                        if (start_i) begin
                            state_d = MC_BUSY;
                            cnt_d   = CNT_LOAD;
                            stall   = 1'b1;
                        end
                    end
                    MC_BUSY: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_ONE;
                            stall = 1'b1;
                        end else begin
                            state_d = MC_IDLE;
                        end
                    end
                    default: begin
                        state_d = MC_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign multistall_o = stall;
            assign busy_o       = (state_q == MC_BUSY);
        end else begin : g_single
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, start_i};
            assign multistall_o  = 1'b0;
            assign busy_o        = 1'b0;
        end
    endgenerate

endmodule : multicycle_tracker
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// hazard_unit_mc : forwarding, load-use/branch/multi-cycle stalls, flushes and
//                  a saturating stall-cycle counter for the 5-stage pipeline
// Rev 1.0
// ============================================================================
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MULTI_LAT   = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_AW-1:0]      RsD,
    input  logic [REG_AW-1:0]      RtD,
    input  logic [REG_AW-1:0]      RsE,
    input  logic [REG_AW-1:0]      RtE,
    input  logic [REG_AW-1:0]      WriteRegE,
    input  logic [REG_AW-1:0]      WriteRegM,
    input  logic [REG_AW-1:0]      WriteRegW,
    input  logic                   RegWriteE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   MemtoRegE,
    input  logic                   MemtoRegM,
    input  logic                   BranchD,
    input  logic                   JumpD,
    input  logic                   PCSrcD,
    input  logic                   MultiStartE,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   StallE,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   FlushM,
    output logic [1:0]             ForwardAD,
    output logic [1:0]             ForwardBD,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic                   MultiBusy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    // Register 0 is hard-wired, so it never produces a dependency.
    function automatic logic src_hit(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src);
        if (RegWriteM && src_hit(src, WriteRegM))      return FWD_E_M;
        else if (RegWriteW && src_hit(src, WriteRegW)) return FWD_E_W;
        else                                           return FWD_E_RF;
    endfunction

    function automatic logic [1:0] fwd_d(input logic [REG_AW-1:0] src);
        if (RegWriteM && src_hit(src, WriteRegM))      return FWD_D_M;
        else if (RegWriteW && src_hit(src, WriteRegW)) return FWD_D_W;
        else                                           return FWD_D_RF;
    endfunction

    logic                   w_lwstall;
    logic                   w_brstall;
    logic                   w_multistall;
    logic                   w_busy;
    logic                   w_stall_f;
    logic                   w_stall_d;
    logic                   w_stall_e;
    logic                   w_flush_e;
    logic                   w_flush_m;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    multicycle_tracker #(
        .MULTI_LAT (MULTI_LAT)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst),
        .start_i      (MultiStartE),
        .multistall_o (w_multistall),
        .busy_o       (w_busy)
    );

    assign w_lwstall = MemtoRegE && (src_hit(RsD, RtE) || src_hit(RtD, RtE));

    assign w_brstall = BranchD &&
        ((RegWriteE && (src_hit(RsD, WriteRegE) || src_hit(RtD, WriteRegE))) ||
         (MemtoRegM && (src_hit(RsD, WriteRegM) || src_hit(RtD, WriteRegM))));

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_flush_e = 1'b0;
        w_flush_m = 1'b0;
        if (w_multistall) begin
            // E is frozen, so the bubble goes into M rather than E.
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_flush_m = 1'b1;
        end else if (w_lwstall || w_brstall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    always_comb begin
        StallF    = w_stall_f;
        StallD    = w_stall_d;
        StallE    = w_stall_e;
        FlushD    = (PCSrcD || JumpD) && !w_stall_d;
        FlushE    = w_flush_e;
        FlushM    = w_flush_m;
        ForwardAD = fwd_d(RsD);
        ForwardBD = fwd_d(RtD);
        ForwardAE = fwd_e(RsE);
        ForwardBE = fwd_e(RtE);
        MultiBusy = w_busy;
        if (!rst) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            ForwardAD = FWD_D_RF;
            ForwardBD = FWD_D_RF;
            ForwardAE = FWD_E_RF;
            ForwardBE = FWD_E_RF;
            MultiBusy = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule : hazard_unit_mc
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// tb_hazard_unit_mc : vector table plus multi-cycle sequences, scoreboard-checked
// Rev 1.0
// ============================================================================
module tb_hazard_unit_mc;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 6;
    localparam int NV  = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic          BranchD, JumpD, PCSrcD, MultiStartE;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MultiBusy;
    logic [1:0]    ForwardAD, ForwardBD, ForwardAE, ForwardBE;
    logic [CW-1:0] StallCount;

    hazard_unit_mc #(
        .REG_AW      (AW),
        .MULTI_LAT   (LAT),
        .STALL_CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RsD         (RsD),
        .RtD         (RtD),
        .RsE         (RsE),
        .RtE         (RtE),
        .WriteRegE   (WriteRegE),
        .WriteRegM   (WriteRegM),
        .WriteRegW   (WriteRegW),
        .RegWriteE   (RegWriteE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemtoRegE   (MemtoRegE),
        .MemtoRegM   (MemtoRegM),
        .BranchD     (BranchD),
        .JumpD       (JumpD),
        .PCSrcD      (PCSrcD),
        .MultiStartE (MultiStartE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .ForwardAD   (ForwardAD),
        .ForwardBD   (ForwardBD),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .MultiBusy   (MultiBusy),
        .StallCount  (StallCount)
    );

    typedef struct packed {
        logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, j_d, pcsrc_d, mstart;
    } in_t;

    typedef struct packed {
        logic sf, sd, se, fd, fe, fm;
        logic [1:0] fad, fbd, fae, fbe;
        logic busy;
    } out_t;

    typedef struct {
        string name;
        out_t  exp;
        logic  chk_cnt;
        logic [CW-1:0] cnt;
    } sb_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[NV];
    int   nvec = 0;
    int   nmis = 0;
    out_t act;

    assign act = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                  ForwardAD, ForwardBD, ForwardAE, ForwardBE, MultiBusy};

    function automatic out_t mk_out(input logic sf, sd, se, fd, fe, fm,
                                    input logic [1:0] fad, fbd, fae, fbe,
                                    input logic busy);
        out_t o;
        o = {sf, sd, se, fd, fe, fm, fad, fbd, fae, fbe, busy};
        return o;
    endfunction

    task automatic drive(input in_t v);
        RsD = v.rs_d;  RtD = v.rt_d;  RsE = v.rs_e;  RtE = v.rt_e;
        WriteRegE = v.wr_e;  WriteRegM = v.wr_m;  WriteRegW = v.wr_w;
        RegWriteE = v.rw_e;  RegWriteM = v.rw_m;  RegWriteW = v.rw_w;
        MemtoRegE = v.m2r_e; MemtoRegM = v.m2r_m;
        BranchD = v.br_d; JumpD = v.j_d; PCSrcD = v.pcsrc_d;
        MultiStartE = v.mstart;
    endtask

    task automatic expect_out(input string name, input out_t exp,
                              input logic chk, input logic [CW-1:0] cnt);
        sb_t e;
        e.name = name; e.exp = exp; e.chk_cnt = chk; e.cnt = cnt;
        sbq.push_back(e);
    endtask

    task automatic check();
        sb_t e;
        nvec++;
        if (sbq.size() == 0) begin
            nmis++;
            $display("FAIL scoreboard_empty: act=%b exp=<none>", act);
            return;
        end
        e = sbq.pop_front();
        if (act !== e.exp) begin
            nmis++;
            $display("FAIL %s: outputs act=%b exp=%b (sf sd se fd fe fm fad fbd fae fbe busy)",
                     e.name, act, e.exp);
        end
        if (e.chk_cnt) begin
            nvec++;
            if (StallCount !== e.cnt) begin
                nmis++;
                $display("FAIL %s: StallCount act=%0d exp=%0d", e.name, StallCount, e.cnt);
            end
        end
    endtask

    task automatic step(input string name, input in_t v, input out_t exp,
                        input logic chk, input logic [CW-1:0] cnt);
        drive(v);
        expect_out(name, exp, chk, cnt);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_t z;
        z = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(z);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t  v;
        out_t o0, o_lw, o_mc, o_rst;
        int   nsat;

        rst = 1'b1;
        v = '0;
        drive(v);
        o0    = mk_out(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        o_lw  = mk_out(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        o_mc  = mk_out(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        o_rst = mk_out(0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);

        // ---------------- combinational vector table ----------------
        v = '0; tbl[0] = '{"quiet", v, o0};
        v = '0; v.rw_m = 1; v.wr_m = 8; v.rs_e = 8; v.rw_w = 1; v.wr_w = 8;
        tbl[1] = '{"fwdAE_M_prio", v, mk_out(0,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,0)};
        v = '0; v.rw_m = 1; v.wr_m = 0; v.rs_e = 0; v.rw_w = 1; v.wr_w = 8;
        tbl[2] = '{"fwdAE_reg0", v, o0};
        v = '0; v.rw_w = 1; v.wr_w = 3; v.rt_e = 3;
        tbl[3] = '{"fwdBE_W", v, mk_out(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0)};
        v = '0; v.rw_m = 0; v.wr_m = 5; v.rs_e = 5;
        tbl[4] = '{"fwdAE_nowrite", v, o0};
        v = '0; v.rw_m = 1; v.wr_m = 6; v.rs_d = 6; v.rw_w = 1; v.wr_w = 7; v.rt_d = 7;
        tbl[5] = '{"fwdD_M_W", v, mk_out(0,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,0)};
        v = '0; v.m2r_e = 1; v.rt_e = 9; v.rs_d = 9;
        tbl[6] = '{"lwstall_rs", v, o_lw};
        v = '0; v.m2r_e = 1;
        tbl[7] = '{"lwstall_reg0", v, o0};
        v = '0; v.br_d = 1; v.rw_e = 1; v.wr_e = 4; v.rt_d = 4; v.pcsrc_d = 1;
        tbl[8] = '{"brstall_E", v, o_lw};
        v = '0; v.br_d = 1; v.m2r_m = 1; v.wr_m = 4; v.rt_d = 4; v.pcsrc_d = 1;
        tbl[9] = '{"brstall_M", v, o_lw};
        v = '0; v.j_d = 1;
        tbl[10] = '{"jump_flush", v, mk_out(0,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0)};
        v = '0; v.br_d = 1; v.pcsrc_d = 1; v.rw_e = 1; v.wr_e = 4; v.rs_d = 5; v.rt_d = 6;
        tbl[11] = '{"branch_taken_nohaz", v, mk_out(0,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0)};
        v = '0; v.m2r_e = 1; v.rt_e = 10; v.rt_d = 10; v.j_d = 1;
        tbl[12] = '{"lwstall_rt_over_jump", v, o_lw};
        v = '0; v.rw_m = 1; v.wr_m = 11; v.rt_e = 11; v.rw_w = 1; v.wr_w = 12; v.rs_e = 12;
        tbl[13] = '{"fwdE_split", v, mk_out(0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b10,0)};

        // Reset state, sampled while rst is held low
        @(posedge clk); #1;
        rst = 1'b0;
        v = '0; v.rw_m = 1; v.wr_m = 8; v.rs_e = 8; v.j_d = 0;
        drive(v);
        #1;
        expect_out("reset_forced", o_rst, 1'b1, '0);
        check();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        do_reset();
        for (int i = 0; i < NV; i++) begin
            step(tbl[i].name, tbl[i].in, tbl[i].exp, 1'b0, '0);
        end

        // ---------------- load-use then clear ----------------
        do_reset();
        v = '0; v.m2r_e = 1; v.rt_e = 9; v.rs_d = 9;
        step("lw_seq_stall", v, o_lw, 1'b1, CW'(0));
        v = '0;
        step("lw_seq_clear", v, o0, 1'b1, CW'(1));

        // ---------------- branch stall overrides redirect ----------------
        v = '0; v.br_d = 1; v.m2r_m = 1; v.wr_m = 4; v.rt_d = 4; v.pcsrc_d = 1;
        step("br_seq_stall", v, o_lw, 1'b0, '0);
        v = '0; v.pcsrc_d = 1;
        step("br_seq_redirect", v, mk_out(0,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, '0);

        // ---------------- multi-cycle op, MultiStartE held 4 cycles ----------------
        do_reset();
        v = '0; v.mstart = 1;
        step("mc_c1", v, o_mc, 1'b1, CW'(0));
        step("mc_c2", v, mk_out(1,1,1,0,0,1,2'b00,2'b00,2'b00,2'b00,1), 1'b1, CW'(1));
        step("mc_c3", v, mk_out(1,1,1,0,0,1,2'b00,2'b00,2'b00,2'b00,1), 1'b1, CW'(2));
        step("mc_c4_release", v, mk_out(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1), 1'b1, CW'(3));
        v.mstart = 0;
        step("mc_c5_idle", v, o0, 1'b1, CW'(3));

        // ---------------- load-use pending across a multi-cycle op ----------------
        do_reset();
        v = '0; v.mstart = 1; v.m2r_e = 1; v.rt_e = 9; v.rs_d = 9;
        step("mclw_c1", v, o_mc, 1'b1, CW'(0));
        step("mclw_c2", v, mk_out(1,1,1,0,0,1,2'b00,2'b00,2'b00,2'b00,1), 1'b1, CW'(1));
        step("mclw_c3", v, mk_out(1,1,1,0,0,1,2'b00,2'b00,2'b00,2'b00,1), 1'b1, CW'(2));
        step("mclw_c4_lw", v, mk_out(1,1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,1), 1'b1, CW'(3));
        v = '0;
        step("mclw_c5", v, o0, 1'b1, CW'(4));

        // ---------------- reset during BUSY ----------------
        do_reset();
        v = '0; v.mstart = 1; v.rw_m = 1; v.wr_m = 8; v.rs_e = 8;
        step("mcrst_c1", v, mk_out(1,1,1,0,0,1,2'b00,2'b00,2'b10,2'b00,0), 1'b1, CW'(0));
        rst = 1'b0;
        #1;
        expect_out("mcrst_forced", o_rst, 1'b1, CW'(0));
        check();
        #2;
        v.mstart = 0;
        drive(v);
        rst = 1'b1;
        expect_out("mcrst_after", mk_out(0,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,0), 1'b1, CW'(0));
        @(negedge clk);
        check();
        @(posedge clk); #1;
        v.mstart = 1;
        step("mcrst_fresh_c1", v, mk_out(1,1,1,0,0,1,2'b00,2'b00,2'b10,2'b00,0), 1'b1, CW'(0));
        step("mcrst_fresh_c2", v, mk_out(1,1,1,0,0,1,2'b00,2'b00,2'b10,2'b00,1), 1'b1, CW'(1));
        step("mcrst_fresh_c3", v, mk_out(1,1,1,0,0,1,2'b00,2'b00,2'b10,2'b00,1), 1'b1, CW'(2));
        step("mcrst_fresh_c4", v, mk_out(0,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,1), 1'b1, CW'(3));
        v.mstart = 0;
        step("mcrst_fresh_c5", v, mk_out(0,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,0), 1'b1, CW'(3));

        // ---------------- StallCount saturation ----------------
        do_reset();
        v = '0; v.m2r_e = 1; v.rt_e = 9; v.rs_d = 9;
        nsat = (1 << CW) + 5;
        for (int k = 0; k <= nsat; k++) begin
            step($sformatf("sat_%0d", k), v, o_lw, 1'b1,
                 (k > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(k));
        end

        if (sbq.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL scoreboard_leftover: act=%0d exp=0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule : tb_hazard_unit_mc
`default_nettype wire
